// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel pushbutton debouncer with press/release/auto-repeat pulses

module debounce_bank #(
  parameter int CHANNELS       = 4,
  parameter int TICK_DIV       = 2000000,
  parameter int STABLE_SAMPLES = 3,
  parameter int HOLD_TICKS     = 50,
  parameter int REPEAT_TICKS   = 10
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat,
  output logic                sample_tick
);

  localparam int CW   = $clog2(TICK_DIV);
  localparam int IW   = $clog2(STABLE_SAMPLES + 1);
  localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] ICNT_LAST = IW'(STABLE_SAMPLES - 1);
  localparam logic [HW-1:0] HOLD_N    = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] REP_N     = HW'(REPEAT_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync_s;
  logic [CW-1:0]       cnt;
  logic                tick;

  logic [IW-1:0]       icnt       [CHANNELS];
  logic [IW-1:0]       icnt_next  [CHANNELS];
  logic [HW-1:0]       hcnt       [CHANNELS];
  logic [HW-1:0]       hcnt_next  [CHANNELS];
  state_t              state      [CHANNELS];
  state_t              state_next [CHANNELS];

  logic [CHANNELS-1:0] level_next;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] press_next;
  logic [CHANNELS-1:0] release_next;
  logic [CHANNELS-1:0] repeat_next;

  assign tick        = (cnt == CNT_LAST);
  assign sample_tick = tick;

  // Two-flop synchroniser per channel and the shared sample prescaler.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_meta <= '0;
      sync_s    <= '0;
      cnt       <= '0;
    end else begin
      sync_meta <= btn;
      sync_s    <= sync_meta;
      cnt       <= tick ? '0 : cnt + CW'(1);
    end
  end

  // Integrator: a run of disagreeing samples flips the level; any agreeing sample restarts it.
  always_comb begin
    level_next = btn_level;
    rise       = '0;
    fall       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      icnt_next[i] = icnt[i];
      if (tick) begin
        if (sync_s[i] == btn_level[i]) begin
          icnt_next[i] = '0;
        end else if (icnt[i] == ICNT_LAST) begin
          level_next[i] = sync_s[i];
          icnt_next[i]  = '0;
          rise[i]       = sync_s[i];
          fall[i]       = ~sync_s[i];
        end else begin
          icnt_next[i] = icnt[i] + IW'(1);
        end
      end
    end
  end

  // Channel FSM: press on rise, hold/repeat tick counting, release on fall (fall wins over repeat).
  always_comb begin
    press_next   = '0;
    release_next = '0;
    repeat_next  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_next[i] = state[i];
      hcnt_next[i]  = hcnt[i];
      if (fall[i]) begin
        release_next[i] = 1'b1;
        hcnt_next[i]    = '0;
        state_next[i]   = IDLE;
      end else begin
        case (state[i])
          IDLE: begin
            if (rise[i]) begin
              press_next[i] = 1'b1;
              hcnt_next[i]  = '0;
              state_next[i] = HELD;
            end
          end
          HELD: begin
            // With no auto-repeat, hcnt parks at HOLD_N so the long-press pulse fires once.
            if (tick && (hcnt[i] != HOLD_N)) begin
              if ((hcnt[i] + HW'(1)) == HOLD_N) begin
                repeat_next[i] = 1'b1;
                if (REPEAT_TICKS == 0) begin
                  hcnt_next[i] = HOLD_N;
                end else begin
                  hcnt_next[i]  = '0;
                  state_next[i] = REPEAT;
                end
              end else begin
                hcnt_next[i] = hcnt[i] + HW'(1);
              end
            end
          end
          REPEAT: begin
            if (tick) begin
              if ((hcnt[i] + HW'(1)) == REP_N) begin
                repeat_next[i] = 1'b1;
                hcnt_next[i]   = '0;
              end else begin
                hcnt_next[i] = hcnt[i] + HW'(1);
              end
            end
          end
          default: begin
            state_next[i] = IDLE;
            hcnt_next[i]  = '0;
          end
        endcase
      end
    end
  end

  // Registered level, pulses and per-channel integrator/FSM state.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        icnt[i]  <= '0;
        hcnt[i]  <= '0;
        state[i] <= IDLE;
      end
    end else begin
      btn_level   <= level_next;
      btn_press   <= press_next;
      btn_release <= release_next;
      btn_repeat  <= repeat_next;
      for (int i = 0; i < CHANNELS; i++) begin
        icnt[i]  <= icnt_next[i];
        hcnt[i]  <= hcnt_next[i];
        state[i] <= state_next[i];
      end
    end
  end

endmodule
